// File: rtl/jogo_sequencia_param_if.sv
// Pad-side signal bundle of the sequence-memory game: player inputs, LEDs and status/score outputs.
// master = player/board side, slave = game engine.
interface jogo_sequencia_param_if #(
    parameter int N_BOTOES = 7,
    parameter int DEPTH    = 16,
    parameter int VIDAS    = 3,
    parameter int PONTOS_W = 8
);
    localparam int RODADA_W = $clog2(DEPTH + 1);
    localparam int VIDAS_W  = $clog2(VIDAS + 1);

    logic                jogar;
    logic                treinamento;
    logic [N_BOTOES-1:0] botoes;
    logic [N_BOTOES-1:0] leds;
    logic                pronto;
    logic                acertou;
    logic                errou;
    logic [PONTOS_W-1:0] pontos;
    logic [RODADA_W-1:0] rodada;
    logic [VIDAS_W-1:0]  vidas_rest;
    logic [3:0]          db_estado;

    modport master (
        output jogar, treinamento, botoes,
        input  leds, pronto, acertou, errou, pontos, rodada, vidas_rest, db_estado
    );

    modport slave (
        input  jogar, treinamento, botoes,
        output leds, pronto, acertou, errou, pontos, rodada, vidas_rest, db_estado
    );
endinterface

// File: rtl/jogo_sequencia_param.sv
// Sequence-memory game engine: LFSR-generated sequence, show/echo rounds, score, lives and training mode.
// Control FSM and datapath live together; the top level only wires pads and displays.
module jogo_sequencia_param #(
    parameter int N_BOTOES    = 7,
    parameter int DEPTH       = 16,
    parameter int SHOW_CYC    = 1000,
    parameter int GAP_CYC     = 250,
    parameter int TIMEOUT_CYC = 5000,
    parameter int PONTOS_W    = 8,
    parameter int PONTOS_INI  = 100,
    parameter int BONUS       = 5,
    parameter int PENAL       = 10,
    parameter int VIDAS       = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    jogo_sequencia_param_if.slave  bus
);
    localparam int IW      = $clog2(N_BOTOES);
    localparam int RW      = $clog2(DEPTH + 1);
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int VW      = $clog2(VIDAS + 1);
    localparam int CNT_MAX = (TIMEOUT_CYC > SHOW_CYC) ?
                             ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC) :
                             ((SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC);
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        PREPARA    = 4'd1,
        MOSTRA     = 4'd2,
        INTERVALO  = 4'd3,
        ESPERA     = 4'd4,
        COMPARA    = 4'd5,
        FIM_RODADA = 4'd6,
        ERRO_JOG   = 4'd7,
        FIM_ACERTO = 4'd8,
        FIM_ERRO   = 4'd9
    } t_estado;

    t_estado             r_state, w_state_nx;
    logic [15:0]         r_lfsr;
    logic                r_jogar_q;
    logic [N_BOTOES-1:0] r_b_q, r_b_prev, r_cap;
    logic [CW-1:0]       r_cnt;
    logic [PONTOS_W-1:0] r_pontos;
    logic [RW-1:0]       r_rodada, r_i;
    logic [VW-1:0]       r_vidas;
    logic                r_treino;
    logic [IW-1:0]       r_item [DEPTH];

    logic                w_jogar_ev, w_press_ev, w_last, w_match, w_round_full, w_lfsr_fb;
    logic                w_show_end, w_gap_end, w_timeout;
    logic [IW-1:0]       w_new_item;
    logic [N_BOTOES-1:0] w_exp_oh, w_leds;
    logic                w_pronto, w_acertou, w_errou;

    function automatic logic [PONTOS_W-1:0] f_sat_add(input logic [PONTOS_W-1:0] a);
        logic [PONTOS_W:0] s;
        s = {1'b0, a} + (PONTOS_W+1)'(BONUS);
        return s[PONTOS_W] ? {PONTOS_W{1'b1}} : s[PONTOS_W-1:0];
    endfunction

    function automatic logic [PONTOS_W-1:0] f_sat_sub(input logic [PONTOS_W-1:0] a);
        if ({1'b0, a} < (PONTOS_W+1)'(PENAL))
            return '0;
        return PONTOS_W'({1'b0, a} - (PONTOS_W+1)'(PENAL));
    endfunction

    assign w_lfsr_fb    = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_new_item   = IW'(r_lfsr % 16'(N_BOTOES));
    assign w_jogar_ev   = bus.jogar & ~r_jogar_q;
    assign w_press_ev   = (r_b_prev == '0) && (r_b_q != '0);
    assign w_exp_oh     = N_BOTOES'(1) << r_item[r_i[AW-1:0]];
    assign w_match      = (r_cap == w_exp_oh);
    assign w_last       = (r_i == r_rodada - RW'(1));
    assign w_round_full = (r_rodada == RW'(DEPTH));
    assign w_show_end   = (r_cnt == CW'(SHOW_CYC - 1));
    assign w_gap_end    = (r_cnt == CW'(GAP_CYC - 1));
    assign w_timeout    = (r_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= INICIAL;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_leds     = '0;
        w_pronto   = 1'b0;
        w_acertou  = 1'b0;
        w_errou    = 1'b0;
        case (r_state)
            INICIAL:    if (w_jogar_ev) w_state_nx = PREPARA;
            PREPARA:    w_state_nx = MOSTRA;
            MOSTRA: begin
                w_leds = w_exp_oh;
                if (w_show_end) w_state_nx = INTERVALO;
            end
            INTERVALO:  if (w_gap_end) w_state_nx = w_last ? ESPERA : MOSTRA;
            ESPERA: begin
                w_leds = r_b_q;
                if (w_press_ev)     w_state_nx = COMPARA;
                else if (w_timeout) w_state_nx = ERRO_JOG;
            end
            COMPARA: begin
                if (!w_match)    w_state_nx = ERRO_JOG;
                else if (w_last) w_state_nx = FIM_RODADA;
                else             w_state_nx = ESPERA;
            end
            FIM_RODADA: w_state_nx = w_round_full ? FIM_ACERTO : MOSTRA;
            // Training never spends a life, so it can only replay.
            ERRO_JOG:   w_state_nx = (!r_treino && r_vidas <= VW'(1)) ? FIM_ERRO : MOSTRA;
            FIM_ACERTO: begin
                w_pronto  = 1'b1;
                w_acertou = 1'b1;
                if (w_jogar_ev) w_state_nx = PREPARA;
            end
            FIM_ERRO: begin
                w_pronto = 1'b1;
                w_errou  = 1'b1;
                if (w_jogar_ev) w_state_nx = PREPARA;
            end
            default:    w_state_nx = INICIAL;
        endcase
    end

    // One shared counter times show, gap and press timeout; any state change or press restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                     r_cnt <= '0;
        else if (w_state_nx != r_state) r_cnt <= '0;
        else                           r_cnt <= r_cnt + CW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lfsr    <= 16'hACE1;
            r_jogar_q <= 1'b0;
            r_b_q     <= '0;
            r_b_prev  <= '0;
            r_pontos  <= PONTOS_W'(PONTOS_INI);
            r_rodada  <= '0;
            r_vidas   <= VW'(VIDAS);
            r_i       <= '0;
            r_treino  <= 1'b0;
        end else begin
            r_lfsr    <= {w_lfsr_fb, r_lfsr[15:1]};
            r_jogar_q <= bus.jogar;
            r_b_q     <= bus.botoes;
            r_b_prev  <= r_b_q;
            case (r_state)
                PREPARA: begin
                    r_pontos <= PONTOS_W'(PONTOS_INI);
                    r_vidas  <= VW'(VIDAS);
                    r_rodada <= RW'(1);
                    r_i      <= '0;
                    r_treino <= bus.treinamento;
                end
                INTERVALO: if (w_gap_end) r_i <= w_last ? '0 : r_i + RW'(1);
                COMPARA:   if (w_match && !w_last) r_i <= r_i + RW'(1);
                FIM_RODADA: begin
                    r_pontos <= f_sat_add(r_pontos);
                    if (!w_round_full) begin
                        r_rodada <= r_rodada + RW'(1);
                        r_i      <= '0;
                    end
                end
                ERRO_JOG: begin
                    r_i <= '0;
                    if (!r_treino) begin
                        r_pontos <= f_sat_sub(r_pontos);
                        r_vidas  <= r_vidas - VW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (r_state == PREPARA)
            r_item[0] <= w_new_item;
        else if (r_state == FIM_RODADA && !w_round_full)
            r_item[r_rodada[AW-1:0]] <= w_new_item;
        if (r_state == ESPERA && w_press_ev)
            r_cap <= r_b_q;
    end

    assign bus.leds       = w_leds;
    assign bus.pronto     = w_pronto;
    assign bus.acertou    = w_acertou;
    assign bus.errou      = w_errou;
    assign bus.pontos     = r_pontos;
    assign bus.rodada     = r_rodada;
    assign bus.vidas_rest = r_vidas;
    assign bus.db_estado  = r_state;
endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Directed bench for jogo_sequencia_param: win, errors, timeout, training, saturation, multi-press and mid-game reset.
// Three engines with different start scores see identical stimulus and therefore walk identical state paths.
module tb_jogo_sequencia_param;
    localparam int NB = 4;
    localparam int DP = 3;
    localparam int VD = 2;
    localparam int PW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          jogar = 1'b0;
    logic          treinamento = 1'b0;
    logic [NB-1:0] botoes = '0;
    logic [15:0]   m_lfsr;
    int            items [DP];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clock = ~clock;

    jogo_sequencia_param_if #(.N_BOTOES(NB), .DEPTH(DP), .VIDAS(VD), .PONTOS_W(PW)) u_if ();
    jogo_sequencia_param_if #(.N_BOTOES(NB), .DEPTH(DP), .VIDAS(VD), .PONTOS_W(PW)) u_if_hi ();
    jogo_sequencia_param_if #(.N_BOTOES(NB), .DEPTH(DP), .VIDAS(VD), .PONTOS_W(PW)) u_if_lo ();

    assign u_if.jogar          = jogar;
    assign u_if.treinamento    = treinamento;
    assign u_if.botoes         = botoes;
    assign u_if_hi.jogar       = jogar;
    assign u_if_hi.treinamento = treinamento;
    assign u_if_hi.botoes      = botoes;
    assign u_if_lo.jogar       = jogar;
    assign u_if_lo.treinamento = treinamento;
    assign u_if_lo.botoes      = botoes;

    jogo_sequencia_param #(.N_BOTOES(NB), .DEPTH(DP), .SHOW_CYC(4), .GAP_CYC(2), .TIMEOUT_CYC(20),
        .PONTOS_W(PW), .PONTOS_INI(100), .BONUS(5), .PENAL(10), .VIDAS(VD))
        u_dut (.clock(clock), .reset(reset), .bus(u_if.slave));
    jogo_sequencia_param #(.N_BOTOES(NB), .DEPTH(DP), .SHOW_CYC(4), .GAP_CYC(2), .TIMEOUT_CYC(20),
        .PONTOS_W(PW), .PONTOS_INI(253), .BONUS(5), .PENAL(10), .VIDAS(VD))
        u_dut_hi (.clock(clock), .reset(reset), .bus(u_if_hi.slave));
    jogo_sequencia_param #(.N_BOTOES(NB), .DEPTH(DP), .SHOW_CYC(4), .GAP_CYC(2), .TIMEOUT_CYC(20),
        .PONTOS_W(PW), .PONTOS_INI(5), .BONUS(5), .PENAL(10), .VIDAS(VD))
        u_dut_lo (.clock(clock), .reset(reset), .bus(u_if_lo.slave));

    // Reference x^16+x^14+x^13+x^11 generator, right-shifting form, stepped every cycle from the reset seed.
    always @(posedge clock or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= (m_lfsr >> 1) |
                             (((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'h0001) << 15);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [NB-1:0] onehot(input int v);
        logic [NB-1:0] one;
        one = 1;
        return one << v;
    endfunction

    function automatic int next_item();
        return int'(m_lfsr % 16'd4);
    endfunction

    // Raise jogar, capture the first item as it is drawn in PREPARA, land in the first MOSTRA cycle.
    task automatic start_game(input logic trn);
        treinamento = trn;
        jogar = 1'b1;
        tick();
        check_val("prepara_state", 32'(u_if.db_estado), 32'd1);
        check_val("prepara_pronto", 32'(u_if.pronto), 32'd0);
        items[0] = next_item();
        jogar = 1'b0;
        tick();
        treinamento = 1'b0;
        check_val("start_pontos", 32'(u_if.pontos), 32'd100);
        check_val("start_rodada", 32'(u_if.rodada), 32'd1);
        check_val("start_vidas", 32'(u_if.vidas_rest), 32'd2);
    endtask

    // From the first MOSTRA cycle: r items of 4 lit + 2 dark cycles each, ending in the first ESPERA cycle.
    task automatic show_round(input int r);
        for (int k = 0; k < r; k++) begin
            check_val("mostra_state", 32'(u_if.db_estado), 32'd2);
            check_val("mostra_leds", 32'(u_if.leds), 32'(onehot(items[k])));
            repeat (4) tick();
            check_val("gap_state", 32'(u_if.db_estado), 32'd3);
            check_val("gap_leds", 32'(u_if.leds), 32'd0);
            repeat (2) tick();
        end
        check_val("espera_state", 32'(u_if.db_estado), 32'd4);
    endtask

    // Press for one cycle then release; returns in the state that follows COMPARA.
    task automatic press(input logic [NB-1:0] v);
        botoes = v;
        tick();
        check_val("espera_echo", 32'(u_if.leds), 32'(v));
        botoes = '0;
        tick();
        tick();
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_state", 32'(u_if.db_estado), 32'd0);
        check_val("rst_leds", 32'(u_if.leds), 32'd0);
        check_val("rst_flags", 32'({u_if.pronto, u_if.acertou, u_if.errou}), 32'd0);
        check_val("rst_pontos", 32'(u_if.pontos), 32'd100);
        check_val("rst_rodada", 32'(u_if.rodada), 32'd0);
        check_val("rst_vidas", 32'(u_if.vidas_rest), 32'd2);
        check_val("rst_pontos_hi", 32'(u_if_hi.pontos), 32'd253);
        reset = 1'b0;
        tick();

        // Full win over three rounds
        start_game(1'b0);
        for (int r = 1; r <= DP; r++) begin
            show_round(r);
            for (int k = 0; k < r; k++) press(onehot(items[k]));
            check_val("fim_rodada_state", 32'(u_if.db_estado), 32'd6);
            if (r < DP) items[r] = next_item();
            tick();
            if (r < DP) begin
                check_val("rodada_inc", 32'(u_if.rodada), 32'(r + 1));
                check_val("bonus", 32'(u_if.pontos), 32'(100 + 5 * r));
                check_val("bonus_sat_hi", 32'(u_if_hi.pontos), 32'd255);
            end
        end
        check_val("win_state", 32'(u_if.db_estado), 32'd8);
        check_val("win_flags", 32'({u_if.pronto, u_if.acertou, u_if.errou}), 32'b110);
        check_val("win_pontos", 32'(u_if.pontos), 32'd115);
        check_val("win_rodada", 32'(u_if.rodada), 32'd3);
        check_val("win_pontos_lo", 32'(u_if_lo.pontos), 32'd20);

        // Two wrong presses lose the game; the same item is replayed in between
        start_game(1'b0);
        show_round(1);
        press(onehot((items[0] + 1) % 4));
        check_val("erro_state", 32'(u_if.db_estado), 32'd7);
        tick();
        check_val("erro1_pontos", 32'(u_if.pontos), 32'd90);
        check_val("erro1_vidas", 32'(u_if.vidas_rest), 32'd1);
        check_val("erro1_pontos_lo", 32'(u_if_lo.pontos), 32'd0);
        show_round(1);
        press(onehot((items[0] + 1) % 4));
        tick();
        check_val("lose_state", 32'(u_if.db_estado), 32'd9);
        check_val("lose_flags", 32'({u_if.pronto, u_if.acertou, u_if.errou}), 32'b101);
        check_val("lose_pontos", 32'(u_if.pontos), 32'd80);
        check_val("lose_vidas", 32'(u_if.vidas_rest), 32'd0);

        // Timeout after 20 idle ESPERA cycles
        start_game(1'b0);
        show_round(1);
        repeat (19) tick();
        check_val("timeout_wait", 32'(u_if.db_estado), 32'd4);
        tick();
        check_val("timeout_erro", 32'(u_if.db_estado), 32'd7);
        tick();
        check_val("timeout_replay", 32'(u_if.db_estado), 32'd2);
        check_val("timeout_vidas", 32'(u_if.vidas_rest), 32'd1);
        check_val("timeout_pontos", 32'(u_if.pontos), 32'd90);

        // Asynchronous reset while an item is lit
        tick();
        reset = 1'b1;
        #1;
        check_val("midrst_state", 32'(u_if.db_estado), 32'd0);
        check_val("midrst_leds", 32'(u_if.leds), 32'd0);
        check_val("midrst_pontos", 32'(u_if.pontos), 32'd100);
        check_val("midrst_vidas", 32'(u_if.vidas_rest), 32'd2);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Training: errors cost nothing and replay the round
        start_game(1'b1);
        show_round(1);
        for (int w = 0; w < 5; w++) begin
            press(onehot((items[0] + 1) % 4));
            check_val("trn_erro", 32'(u_if.db_estado), 32'd7);
            tick();
            check_val("trn_replay", 32'(u_if.db_estado), 32'd2);
            check_val("trn_pontos", 32'(u_if.pontos), 32'd100);
            check_val("trn_vidas", 32'(u_if.vidas_rest), 32'd2);
            show_round(1);
        end
        press(onehot(items[0]));
        check_val("trn_ok", 32'(u_if.db_estado), 32'd6);
        items[1] = next_item();
        tick();
        check_val("trn_rodada", 32'(u_if.rodada), 32'd2);
        check_val("trn_bonus", 32'(u_if.pontos), 32'd105);

        // Two buttons at once is a mismatch
        show_round(2);
        press(4'b0011);
        check_val("multi_erro", 32'(u_if.db_estado), 32'd7);
        tick();
        check_val("multi_pontos", 32'(u_if.pontos), 32'd105);

        // A button held from MOSTRA into ESPERA is not a press until released and pressed again
        botoes = onehot(items[0]);
        show_round(2);
        repeat (3) tick();
        check_val("held_no_press", 32'(u_if.db_estado), 32'd4);
        check_val("held_echo", 32'(u_if.leds), 32'(onehot(items[0])));
        botoes = '0;
        tick();
        press(onehot(items[0]));
        press(onehot(items[1]));
        check_val("held_round_ok", 32'(u_if.db_estado), 32'd6);
        tick();
        check_val("held_rodada", 32'(u_if.rodada), 32'd3);
        check_val("held_pontos", 32'(u_if.pontos), 32'd110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/jogo_sequencia_param.md
Name: jogo_sequencia_param

Overview:
Parametrised sequence-memory game engine. It succeeds the fixed 7-button S1 game circuit and merges control and datapath into one block. It adds configurable button count, sequence depth, timing and score width. It also adds internal LFSR sequence generation, a lives counter, saturating score arithmetic, and built-in edge detection for jogar and botoes; the top level only wires pads and displays.

Parameters:
N_BOTOES, 7, number of buttons/LEDs (2..16)
DEPTH, 16, maximum sequence length (rounds to win)
SHOW_CYC, 1000, clock cycles each item is shown on leds
GAP_CYC, 250, dark cycles between shown items and before ESPERA
TIMEOUT_CYC, 5000, cycles allowed per press in ESPERA
PONTOS_W, 8, score width
PONTOS_INI, 100, score loaded on game start and reset
BONUS, 5, points added per completed round
PENAL, 10, points subtracted per error (non-training)
VIDAS, 3, errors tolerated before game over

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, active-high
jogar  in  1  start request, level; rising edge detected internally
treinamento  in  1  training mode, sampled at game start
botoes  in  N_BOTOES  player buttons, active-high
leds  out  N_BOTOES  button LEDs (shown sequence / press echo)
pronto  out  1  game finished
acertou  out  1  game won
errou  out  1  game lost
pontos  out  PONTOS_W  current score
rodada  out  clog2(DEPTH+1)  current round (sequence length)
vidas_rest  out  clog2(VIDAS+1)  lives remaining
db_estado  out  4  FSM state code

Behaviour:
- Reset (async): state INICIAL(0); leds=0; pronto/acertou/errou=0; pontos=PONTOS_INI; rodada=0; vidas_rest=VIDAS; LFSR=16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-runs every cycle, never zero. New item = lfsr mod N_BOTOES. Items are stored in an internal DEPTH x clog2(N_BOTOES) register file.
- Edge detection: jogar_ev = jogar & ~jogar_q. Buttons are registered as b_q; press_ev = (b_q_prev==0) & (b_q!=0). The captured value is compared with the one-hot of the expected item. A non-one-hot press is a mismatch.
- FSM states and codes:
  - INICIAL(0): jogar_ev -> PREPARA.
  - PREPARA(1): one cycle. pontos=PONTOS_INI, vidas_rest=VIDAS, rodada=1, item[0]=new item, mode latched from treinamento, index i=0; -> MOSTRA.
  - MOSTRA(2): leds=onehot(item[i]) for SHOW_CYC cycles; -> INTERVALO.
  - INTERVALO(3): leds=0 for GAP_CYC cycles. If i<rodada-1: i++, -> MOSTRA. Else i=0, -> ESPERA.
  - ESPERA(4): leds=b_q. press_ev -> COMPARA. Timeout counter reaching TIMEOUT_CYC-1 -> ERRO_JOG. The timeout counter clears on entry and on each press.
  - COMPARA(5): one cycle. Mismatch -> ERRO_JOG. Match with i<rodada-1: i++, -> ESPERA. Match with i==rodada-1 -> FIM_RODADA.
  - FIM_RODADA(6): pontos=min(pontos+BONUS, 2^PONTOS_W-1). If rodada==DEPTH -> FIM_ACERTO. Else item[rodada]=new item, rodada++, i=0, -> MOSTRA.
  - ERRO_JOG(7): if not training, pontos=max(pontos-PENAL,0) and vidas_rest--. If vidas_rest becomes 0 -> FIM_ERRO. Otherwise i=0, -> MOSTRA (replay same round, same sequence).
  - FIM_ACERTO(8): pronto=1, acertou=1. FIM_ERRO(9): pronto=1, errou=1. In both, jogar_ev -> PREPARA and clears pronto/acertou/errou on that edge.
- Timing: the press registers at edge t. COMPARA runs at t+1. The next state is entered at t+2.
- Timing rules:
  - jogar_ev is ignored outside INICIAL and FIM states.
  - A press during MOSTRA or INTERVALO is ignored and does not count in ESPERA. An edge is needed after buttons return to 0.
  - Held buttons at ESPERA entry produce no press_ev until released.
- Training: vidas_rest and pontos never decrease, and errors replay the round. BONUS still applies.
- Reset mid-game returns immediately to INICIAL with reset values.

Test Plan:
(N_BOTOES=4, DEPTH=3, SHOW_CYC=4, GAP_CYC=2, TIMEOUT_CYC=20, PONTOS_W=8, VIDAS=2 unless stated.)
1. Reset, then pulse jogar, then echo every shown item within 5 cycles for 3 rounds -> acertou=1, pronto=1, errou=0, pontos=115, rodada=3, db_estado=8.
2. Start, then press a wrong button in round 1 twice, replaying in between -> after 1st error pontos=90 and vidas_rest=1. Item 0 is replayed with the same value. After 2nd error pontos=80, errou=1, db_estado=9.
3. Start, then no press for 20 cycles in ESPERA -> ERRO_JOG taken, vidas_rest=1, pontos=90, replay begins.
4. treinamento=1, start, then 5 wrong presses -> pontos stays 100, vidas_rest=2, game still running. A correct press afterwards advances the game.
5. PONTOS_INI=253, BONUS=5 -> pontos saturates at 255. PONTOS_INI=5, PENAL=10 -> an error gives 0.
6. Press two buttons simultaneously (4'b0011) in ESPERA -> treated as a mismatch. Separately, assert reset during MOSTRA -> INICIAL, leds=0, pontos=PONTOS_INI.
